// File: rtl/ram_arbiter.sv
// ram_arbiter: two-client arbiter (video reads, terminal writes) in front of a
// single RAM port pair, with at most one RAM transaction outstanding.
// Ports:
//   clk, reset (async, active high)
//   vid_rd_*  : video read request/params in, read data strobe/word out
//   term_wr_* : terminal write request/params/data in, done pulse out
//   ram_rd_*  : RAM read request/params out, data strobe/word in
//   ram_wr_*  : RAM write request/params/data out, done strobe in
//   busy      : high whenever the FSM is not idle
// Option: define RAM_ARB_STARVE_LIMIT_EN to bound consecutive video grants
// while a write waits (STARVE_LIMIT); otherwise video has strict priority.
module ram_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        vid_rd_request,
    input  logic [22:0] vid_rd_address,
    input  logic [8:0]  vid_rd_burst_length,
    output logic        vid_rd_available,
    output logic [31:0] vid_rd_data,
    input  logic        term_wr_request,
    input  logic [22:0] term_wr_address,
    input  logic [3:0]  term_wr_mask,
    input  logic [8:0]  term_wr_burst_length,
    input  logic [31:0] term_wr_data,
    output logic        term_wr_done,
    output logic        ram_rd_request,
    output logic [22:0] ram_rd_address,
    output logic [8:0]  ram_rd_burst_length,
    input  logic        ram_rd_available,
    input  logic [31:0] ram_rd_data,
    output logic        ram_wr_request,
    output logic [22:0] ram_wr_address,
    output logic [3:0]  ram_wr_mask,
    output logic [8:0]  ram_wr_burst_length,
    output logic [31:0] ram_wr_data,
    input  logic        ram_wr_done,
    output logic        busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_ISSUE,
        S_RD_WAIT,
        S_WR_ISSUE,
        S_WR_WAIT
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic        r_vid_pend;
    logic        r_wr_pend;
    logic [22:0] r_rd_addr;
    logic [8:0]  r_rd_len;
    logic [22:0] r_wr_addr;
    logic [3:0]  r_wr_mask;
    logic [8:0]  r_wr_len;
    logic [8:0]  r_words;
    logic        r_vid_av;
    logic [31:0] r_vid_data;
    logic        w_rd_clr;
    logic        w_wr_clr;
    logic        w_rd_grant;
    logic        w_wr_grant;
    logic        w_force_wr;
    logic        w_last;
    logic        w_rd_cap;
    logic [8:0]  w_rd_tgt;

    assign w_rd_clr = (r_state == S_RD_ISSUE);
    assign w_wr_clr = (r_state == S_WR_ISSUE);
    // A zero-length burst still moves one word.
    assign w_rd_tgt = (r_rd_len == 9'd0) ? 9'd1 : r_rd_len;
    // r_words counts the words still owed in the active read.
    assign w_last   = (r_words == 9'd1);
    assign w_rd_cap = (r_state == S_RD_WAIT) && ram_rd_available;

    always_comb begin
        w_next     = r_state;
        w_rd_grant = 1'b0;
        w_wr_grant = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (r_vid_pend && !w_force_wr) begin
                    w_next     = S_RD_ISSUE;
                    w_rd_grant = 1'b1;
                end else if (r_wr_pend) begin
                    w_next     = S_WR_ISSUE;
                    w_wr_grant = 1'b1;
                end
            end
            S_RD_ISSUE: w_next = S_RD_WAIT;
            S_RD_WAIT:  if (ram_rd_available && w_last) w_next = S_IDLE;
            S_WR_ISSUE: w_next = S_WR_WAIT;
            S_WR_WAIT:  if (ram_wr_done) w_next = S_IDLE;
            default:    w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_vid_pend <= 1'b0;
            r_wr_pend  <= 1'b0;
            r_rd_addr  <= '0;
            r_rd_len   <= '0;
            r_wr_addr  <= '0;
            r_wr_mask  <= '0;
            r_wr_len   <= '0;
            r_words    <= '0;
            r_vid_av   <= 1'b0;
            r_vid_data <= '0;
        end else begin
            r_state <= w_next;
            // A pulse landing on the clearing cycle re-arms the client.
            if (vid_rd_request && (!r_vid_pend || w_rd_clr)) begin
                r_vid_pend <= 1'b1;
                r_rd_addr  <= vid_rd_address;
                r_rd_len   <= vid_rd_burst_length;
            end else if (w_rd_clr) begin
                r_vid_pend <= 1'b0;
            end
            if (term_wr_request && (!r_wr_pend || w_wr_clr)) begin
                r_wr_pend <= 1'b1;
                r_wr_addr <= term_wr_address;
                r_wr_mask <= term_wr_mask;
                r_wr_len  <= term_wr_burst_length;
            end else if (w_wr_clr) begin
                r_wr_pend <= 1'b0;
            end
            // Snapshot the target at issue: params may be relatched later.
            if (w_rd_clr) begin
                r_words <= w_rd_tgt;
            end else if (w_rd_cap) begin
                r_words <= r_words - 9'd1;
            end
            r_vid_av <= w_rd_cap;
            if (w_rd_cap) begin
                r_vid_data <= ram_rd_data;
            end
        end
    end

`ifdef RAM_ARB_STARVE_LIMIT_EN
    localparam int unsigned LP_SW =
        (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

    logic [LP_SW-1:0] r_starve;

    // Consecutive video grants while a write waits; never exceeds the
    // limit because reaching it diverts the next grant to the write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_starve <= '0;
        end else if (!r_wr_pend || w_wr_grant) begin
            r_starve <= '0;
        end else if (w_rd_grant) begin
            r_starve <= r_starve + LP_SW'(1);
        end
    end

    assign w_force_wr = r_wr_pend && (r_starve >= LP_SW'(STARVE_LIMIT));
`else
    logic w_unused_limit;

    // Limit is meaningless under strict video priority.
    assign w_unused_limit = |STARVE_LIMIT;
    assign w_force_wr     = 1'b0;
`endif

    assign ram_rd_request      = (r_state == S_RD_ISSUE);
    assign ram_rd_address      = r_rd_addr;
    assign ram_rd_burst_length = r_rd_len;
    assign ram_wr_request      = (r_state == S_WR_ISSUE);
    assign ram_wr_address      = r_wr_addr;
    assign ram_wr_mask         = r_wr_mask;
    assign ram_wr_burst_length = r_wr_len;
    assign ram_wr_data         = term_wr_data;
    assign term_wr_done        = (r_state == S_WR_WAIT) && ram_wr_done;
    assign vid_rd_available    = r_vid_av;
    assign vid_rd_data         = r_vid_data;
    assign busy                = (r_state != S_IDLE);

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed scenarios plus randomized traffic for ram_arbiter,
// checked every cycle against a transaction-level model.
module tb_ram_arbiter;

    localparam int SL = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        vid_rd_request;
    logic [22:0] vid_rd_address;
    logic [8:0]  vid_rd_burst_length;
    logic        vid_rd_available;
    logic [31:0] vid_rd_data;
    logic        term_wr_request;
    logic [22:0] term_wr_address;
    logic [3:0]  term_wr_mask;
    logic [8:0]  term_wr_burst_length;
    logic [31:0] term_wr_data;
    logic        term_wr_done;
    logic        ram_rd_request;
    logic [22:0] ram_rd_address;
    logic [8:0]  ram_rd_burst_length;
    logic        ram_rd_available;
    logic [31:0] ram_rd_data;
    logic        ram_wr_request;
    logic [22:0] ram_wr_address;
    logic [3:0]  ram_wr_mask;
    logic [8:0]  ram_wr_burst_length;
    logic [31:0] ram_wr_data;
    logic        ram_wr_done;
    logic        busy;

    ram_arbiter #(.STARVE_LIMIT(SL)) dut (
        .clk(clk), .reset(reset),
        .vid_rd_request(vid_rd_request),
        .vid_rd_address(vid_rd_address),
        .vid_rd_burst_length(vid_rd_burst_length),
        .vid_rd_available(vid_rd_available),
        .vid_rd_data(vid_rd_data),
        .term_wr_request(term_wr_request),
        .term_wr_address(term_wr_address),
        .term_wr_mask(term_wr_mask),
        .term_wr_burst_length(term_wr_burst_length),
        .term_wr_data(term_wr_data),
        .term_wr_done(term_wr_done),
        .ram_rd_request(ram_rd_request),
        .ram_rd_address(ram_rd_address),
        .ram_rd_burst_length(ram_rd_burst_length),
        .ram_rd_available(ram_rd_available),
        .ram_rd_data(ram_rd_data),
        .ram_wr_request(ram_wr_request),
        .ram_wr_address(ram_wr_address),
        .ram_wr_mask(ram_wr_mask),
        .ram_wr_burst_length(ram_wr_burst_length),
        .ram_wr_data(ram_wr_data),
        .ram_wr_done(ram_wr_done),
        .busy(busy)
    );

    always #20 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: m_act 0 = nothing in flight, 1 = read, 2 = write.
    // m_sent marks that the RAM request has already gone out.
    int          m_act;
    bit          m_sent;
    int          m_left;
    bit          m_vp, m_wp;
    logic [22:0] m_ra, m_wa;
    logic [8:0]  m_rl, m_wl;
    logic [3:0]  m_wm;
    bit          m_vav;
    logic [31:0] m_vdat;
    int          m_streak;

    function automatic void m_reset();
        m_act = 0; m_sent = 0; m_left = 0; m_vp = 0; m_wp = 0;
        m_ra = '0; m_wa = '0; m_rl = '0; m_wl = '0; m_wm = '0;
        m_vav = 0; m_vdat = '0; m_streak = 0;
    endfunction

    function automatic void model_step();
        bit vp0, wp0, clr_v, clr_w, g_rd, g_wr, force_w;
        if (reset) begin
            m_reset();
            return;
        end
        vp0 = m_vp;
        wp0 = m_wp;
        clr_v = (m_act == 1) && !m_sent;
        clr_w = (m_act == 2) && !m_sent;
        g_rd = 0;
        g_wr = 0;
        force_w = 0;
        m_vav = (m_act == 1) && m_sent && ram_rd_available;
        if (m_vav) m_vdat = ram_rd_data;
`ifdef RAM_ARB_STARVE_LIMIT_EN
        force_w = wp0 && (m_streak >= SL);
`endif
        if (m_act == 0) begin
            if (vp0 && !force_w) g_rd = 1;
            else if (wp0) g_wr = 1;
        end else if (!m_sent) begin
            m_sent = 1;
        end else if (m_act == 1) begin
            if (ram_rd_available) begin
                m_left--;
                if (m_left == 0) m_act = 0;
            end
        end else if (ram_wr_done) begin
            m_act = 0;
        end
        if (g_rd) begin
            m_act = 1; m_sent = 0;
            m_left = (m_rl == 0) ? 1 : int'(m_rl);
        end
        if (g_wr) begin
            m_act = 2; m_sent = 0;
        end
`ifdef RAM_ARB_STARVE_LIMIT_EN
        if (!wp0 || g_wr) m_streak = 0;
        else if (g_rd) m_streak++;
`endif
        if (vid_rd_request && (!vp0 || clr_v)) begin
            m_vp = 1; m_ra = vid_rd_address; m_rl = vid_rd_burst_length;
        end else if (clr_v) m_vp = 0;
        if (term_wr_request && (!wp0 || clr_w)) begin
            m_wp = 1; m_wa = term_wr_address;
            m_wm = term_wr_mask; m_wl = term_wr_burst_length;
        end else if (clr_w) m_wp = 0;
    endfunction

    bit chk_on = 0;

    always @(negedge clk) begin
        if (chk_on) begin
            chk("busy", busy, m_act != 0);
            chk("rd_req", ram_rd_request, (m_act == 1) && !m_sent);
            chk("wr_req", ram_wr_request, (m_act == 2) && !m_sent);
            chk("vid_av", vid_rd_available, m_vav);
            chk("wr_done", term_wr_done,
                (m_act == 2) && m_sent && ram_wr_done);
            chk("wr_data", ram_wr_data, term_wr_data);
            if (m_vav) chk("vid_data", vid_rd_data, m_vdat);
            if ((m_act == 1) && !m_sent) begin
                chk("rd_addr", ram_rd_address, m_ra);
                chk("rd_len", ram_rd_burst_length, m_rl);
            end
            if ((m_act == 2) && !m_sent) begin
                chk("wr_addr", ram_wr_address, m_wa);
                chk("wr_mask", ram_wr_mask, m_wm);
                chk("wr_len", ram_wr_burst_length, m_wl);
            end
        end
    end

    int          cyc_n = 0, n_vid = 0, n_rdq = 0, n_wrq = 0;
    int          t_rdq = 0, t_wrq = 0;
    logic [31:0] last_vdat = '0;

    always @(negedge clk) begin
        cyc_n++;
        if (vid_rd_available) begin
            n_vid++;
            last_vdat = vid_rd_data;
        end
        if (ram_rd_request) begin n_rdq++; t_rdq = cyc_n; end
        if (ram_wr_request) begin n_wrq++; t_wrq = cyc_n; end
    end

    bit auto_rsp = 0;

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        vid_rd_request   = 0;
        term_wr_request  = 0;
        ram_rd_available = auto_rsp;
        ram_wr_done      = auto_rsp;
    endtask

    task automatic do_reset();
        reset = 1;
        m_reset();
        cyc();
        cyc();
        reset = 0;
    endtask

    task automatic wait_req(input bit wr, input string nm);
        bit seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            cyc();
            seen = wr ? ram_wr_request : ram_rd_request;
        end
        chk(nm, {31'd0, seen}, 1);
    endtask

    task automatic give_words(input int n, input logic [31:0] base);
        for (int k = 0; k < n; k++) begin
            ram_rd_available = 1;
            ram_rd_data = base + k;
            cyc();
        end
    endtask

    int nv0, r0, w0;

    initial begin
        reset = 1;
        vid_rd_request = 0; vid_rd_address = '0; vid_rd_burst_length = '0;
        term_wr_request = 0; term_wr_address = '0; term_wr_mask = '0;
        term_wr_burst_length = '0; term_wr_data = '0;
        ram_rd_available = 0; ram_rd_data = '0; ram_wr_done = 0;
        m_reset();
        #5;
        chk("rst_outs", {busy, ram_rd_request, ram_wr_request,
                         vid_rd_available, term_wr_done}, 0);
        chk("rst_raddr", ram_rd_address, 0);
        chk("rst_wmask", ram_wr_mask, 0);
        chk_on = 1;
        do_reset();

        // Four-word video read.
        vid_rd_request = 1; vid_rd_address = 23'h000100;
        vid_rd_burst_length = 9'd4;
        nv0 = n_vid;
        wait_req(0, "A_rdq");
        chk("A_raddr", ram_rd_address, 32'h100);
        cyc();
        give_words(4, 32'hA0);
        cyc();
        cyc();
        chk("A_vid_cnt", n_vid - nv0, 4);
        chk("A_last", last_vdat, 32'hA3);
        chk("A_busy", busy, 0);

        // Simultaneous requests: read first, write after turnaround.
        do_reset();
        vid_rd_request = 1; vid_rd_address = 23'h000200;
        vid_rd_burst_length = 9'd4;
        term_wr_request = 1; term_wr_address = 23'h001234;
        term_wr_mask = 4'h3; term_wr_burst_length = 9'd2;
        wait_req(0, "B_rdq");
        chk("B_no_wr", ram_wr_request, 0);
        cyc();
        give_words(4, 32'hB0);
        wait_req(1, "B_wrq");
        cyc();
        chk("B_gap", t_wrq - t_rdq, 6);
        ram_wr_done = 1;
        cyc();
        cyc();

        // Top-of-memory single write.
        do_reset();
        term_wr_request = 1; term_wr_address = 23'h7FFFFF;
        term_wr_mask = 4'hF; term_wr_burst_length = 9'd1;
        term_wr_data = 32'hDEADBEEF;
        w0 = n_wrq;
        wait_req(1, "C_wrq");
        chk("C_addr", ram_wr_address, 32'h7FFFFF);
        chk("C_mask", ram_wr_mask, 32'hF);
        chk("C_len", ram_wr_burst_length, 1);
        cyc();
        chk("C_done_lo", term_wr_done, 0);
        ram_wr_done = 1;
        #1;
        chk("C_done", term_wr_done, 1);
        cyc();
        cyc();
        chk("C_wrq_cnt", n_wrq - w0, 1);
        chk("C_busy", busy, 0);

        // Continuous video with a write waiting.
        do_reset();
        auto_rsp = 1; ram_rd_available = 1; ram_wr_done = 1;
        vid_rd_address = 23'h40; vid_rd_burst_length = 9'd1;
        term_wr_request = 1; term_wr_address = 23'h55;
        term_wr_burst_length = 9'd1;
        r0 = n_rdq;
        w0 = n_wrq;
        for (int i = 0; i < 60; i++) begin
            vid_rd_request = 1;
            cyc();
`ifdef RAM_ARB_STARVE_LIMIT_EN
            if (n_wrq != w0) break;
`endif
        end
`ifdef RAM_ARB_STARVE_LIMIT_EN
        chk("D_wr_grant", n_wrq - w0, 1);
        chk("D_reads", n_rdq - r0, SL);
`else
        chk("D_no_wr", n_wrq - w0, 0);
        for (int i = 0; i < 20; i++) cyc();
        chk("D_wr_after", n_wrq - w0, 1);
`endif
        auto_rsp = 0;
        for (int i = 0; i < 6; i++) cyc();

        // Reset in the middle of an eight-word read.
        do_reset();
        vid_rd_request = 1; vid_rd_address = 23'h300;
        vid_rd_burst_length = 9'd8;
        wait_req(0, "E_rdq");
        cyc();
        give_words(2, 32'hE0);
        chk("E_pre_av", vid_rd_available, 1);
        #5;
        reset = 1;
        m_reset();
        #1;
        chk("E_outs", {busy, ram_rd_request, ram_wr_request,
                       vid_rd_available, term_wr_done}, 0);
        chk("E_raddr", ram_rd_address, 0);
        nv0 = n_vid;
        cyc();
        reset = 0;
        give_words(6, 32'hE2);
        cyc();
        cyc();
        chk("E_no_vid", n_vid - nv0, 0);
        chk("E_busy", busy, 0);

        // Zero-length burst moves exactly one word.
        do_reset();
        vid_rd_request = 1; vid_rd_address = 23'h10;
        vid_rd_burst_length = 9'd0;
        nv0 = n_vid;
        wait_req(0, "F_rdq");
        cyc();
        give_words(1, 32'hF0);
        chk("F_busy", busy, 0);
        give_words(1, 32'hF1);
        cyc();
        cyc();
        chk("F_vid_cnt", n_vid - nv0, 1);
        chk("F_data", last_vdat, 32'hF0);

        // Randomized traffic, stray strobes and occasional resets.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            vid_rd_request = ($urandom % 4) == 0;
            vid_rd_address = 23'($urandom);
            vid_rd_burst_length = 9'($urandom % 6);
            term_wr_request = ($urandom % 5) == 0;
            term_wr_address = 23'($urandom);
            term_wr_mask = 4'($urandom);
            term_wr_burst_length = 9'($urandom % 6);
            term_wr_data = $urandom;
            ram_rd_available = ($urandom % 2) == 0;
            ram_rd_data = $urandom;
            ram_wr_done = ($urandom % 3) == 0;
            reset = ($urandom % 400) == 0;
            if (reset) m_reset();
            cyc();
        end
        reset = 0;
        cyc();
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
